arbitro_contador: RTL and testbench
===================================

ARBITRO_CONTADOR -- requirements
Module: arbitro_contador

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the shared up-counter and of the length inputs.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port enable, input, 1, count-advance qualifier for the shared counter.
REQ-005 The block SHALL have port req, input, 2, one request line per requester (bit 0 = requester 0).
REQ-006 The block SHALL have port len0, input, WIDTH, terminal count requested by requester 0.
REQ-007 The block SHALL have port len1, input, WIDTH, terminal count requested by requester 1.
REQ-008 The block SHALL have port gnt, output, 2, one-hot-or-zero grant, registered.
REQ-009 The block SHALL have port done, output, 2, one-cycle completion pulse per requester, registered.
REQ-010 The block SHALL have port busy, output, 1, high whenever the counter is owned (states RUN, FIN).
REQ-011 The block SHALL have port cuenta, output, WIDTH, current value of the shared counter, registered.

Function
REQ-012 The block SHALL implement the three-state FSM IDLE -> RUN -> FIN -> IDLE, with an additional RUN -> IDLE abort path.
REQ-013 In IDLE with req != 0, the block SHALL select a winner, latch the winner's len as target, clear cuenta to 0, set gnt to the winner's one-hot, and enter RUN on the same edge.
REQ-014 Arbitration SHALL be round-robin on a 1-bit last-served pointer: on a single request, that requester wins; when both request, the requester not last served wins.
REQ-015 In RUN, if cuenta != target and enable=1, cuenta SHALL increment by 1; if enable=0, cuenta SHALL hold.
REQ-016 In RUN, when cuenta == target and enable=1, the FSM SHALL enter FIN; with enable=0 it SHALL remain in RUN.
REQ-017 target = 0 SHALL complete after one RUN cycle when enable=1; no increment SHALL occur.
REQ-018 cuenta SHALL never wrap, since the target is at most 2^WIDTH-1 and counting stops at the target.
REQ-019 On entry to FIN, gnt SHALL go to 0, done[winner] SHALL be 1 for exactly the FIN cycle, and the pointer SHALL be updated to the winner; the next state SHALL be IDLE.
REQ-020 If the owner's req bit is 0 in any RUN cycle, the block SHALL abort: gnt goes to 0, the state goes to IDLE, no done is issued, and the pointer is updated to the owner.
REQ-021 When an abort and a completion occur in the same cycle, the abort SHALL take priority and no done SHALL be issued.
REQ-022 Changes to len0 and len1 and to the non-owner req after the grant SHALL have no effect on the run in progress.
REQ-023 cuenta SHALL hold its final value through FIN and IDLE until the next grant clears it.
REQ-024 With req held, the minimum request-to-request turnaround SHALL be: FIN, then IDLE with re-arbitration on the following edge.
REQ-025 Latency SHALL be as follows: req seen at edge k gives gnt visible after edge k; with enable=1 throughout and len=L, gnt is high for L+1 cycles and done follows immediately.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set state=IDLE, cuenta=0, gnt=0, done=0, busy=0, and pointer=1 (requester 0 has priority first).
REQ-027 Reset SHALL take priority over all other activity, including mid-RUN and in FIN; no done SHALL be emitted for an interrupted run.

Verification
REQ-028 Test: reset, then req=01, len0=3, enable=1 -> gnt=01 for 4 cycles with cuenta 0,1,2,3, then done=01 for 1 cycle, gnt=00, busy=0 after FIN.
REQ-029 Test: req=11 held, len0=2, len1=1 -> requester 0 served first (3 cycles), then requester 1 (2 cycles), then requester 0 again; grants alternate.
REQ-030 Test: req=01, len0=4, enable low for 2 cycles while cuenta=2 -> cuenta holds at 2 and gnt stays high 2 extra cycles, for 7 gnt cycles total.
REQ-031 Test: len0=0, req=01 -> gnt high 1 cycle, cuenta=0, done=01 the next cycle.
REQ-032 Test: drop req[0] while cuenta=1 of len0=5 -> gnt=00 the next cycle, no done, cuenta holds at 1, and a pending req[1] is granted on the following edge.
REQ-033 Test: assert rst mid-RUN at cuenta=3 -> all outputs 0 the next cycle, no done pulse, and a subsequent req=11 grants requester 0.

Source files
------------

// File: rtl/arbitro_contador.sv
// Two-requester round-robin arbiter that lends a shared up-counter to the winner
// until it reaches the winner's requested terminal count.
module arbitro_contador #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] cuenta
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic             owner;
    logic             last;
    logic             winner;
    logic             owner_req;

    // On contention the requester not served last wins.
    assign winner    = (req == 2'b11) ? ~last : req[1];
    assign owner_req = req[owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            target <= '0;
            owner  <= 1'b0;
            last   <= 1'b1;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            cuenta <= '0;
        end else begin
            done <= '0;
            unique case (state)
                StIdle: begin
                    if (req != 2'b00) begin
                        owner  <= winner;
                        target <= winner ? len1 : len0;
                        cuenta <= '0;
                        gnt    <= winner ? 2'b10 : 2'b01;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    // Abort outranks completion: a dropped request never sees done.
                    if (!owner_req) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        last  <= owner;
                        state <= StIdle;
                    end else if (enable) begin
                        if (cuenta == target) begin
                            gnt         <= '0;
                            done[owner] <= 1'b1;
                            last        <= owner;
                            state       <= StFin;
                        end else begin
                            cuenta <= cuenta + WIDTH'(1);
                        end
                    end
                end
                StFin: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_contador.sv
// Randomized and directed bench for arbitro_contador; a transaction-level model
// predicts each cycle's outputs into a queue that a separate monitor drains.
module tb_arbitro_contador;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst, enable;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0, len1;
    logic [1:0]       gnt, done;
    logic             busy;
    logic [WIDTH-1:0] cuenta;

    arbitro_contador #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cuenta (cuenta)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       gnt;
        logic [1:0]       done;
        logic             busy;
        logic [WIDTH-1:0] cuenta;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   gnt_cycles = 0;
    int   done_pulses = 0;

    // Reference model: who owns the counter, how far it has counted, who went last.
    int m_owner   = -1;
    bit m_fin     = 0;
    int m_target  = 0;
    int m_cnt     = 0;
    int m_last    = 1;
    int m_done_to = -1;

    function automatic obs_t model_step(bit r, bit en, logic [1:0] rq, int l0, int l1);
        obs_t o;
        m_done_to = -1;
        if (r) begin
            m_owner = -1; m_fin = 0; m_cnt = 0; m_last = 1;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_owner < 0) begin
            if (rq != 2'b00) begin
                if (rq == 2'b11) m_owner = 1 - m_last;
                else             m_owner = rq[1] ? 1 : 0;
                m_target = (m_owner == 1) ? l1 : l0;
                m_cnt    = 0;
            end
        end else if (!rq[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (en) begin
            if (m_cnt == m_target) begin
                m_done_to = m_owner;
                m_last    = m_owner;
                m_owner   = -1;
                m_fin     = 1;
            end else begin
                m_cnt++;
            end
        end
        o.gnt    = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        o.done   = (m_done_to == 0) ? 2'b01 : (m_done_to == 1) ? 2'b10 : 2'b00;
        o.busy   = (m_owner >= 0) || m_fin;
        o.cuenta = WIDTH'(m_cnt);
        return o;
    endfunction

    task automatic drive(bit r, bit en, logic [1:0] rq, int l0, int l1);
        rst    = r;
        enable = en;
        req    = rq;
        len0   = WIDTH'(l0);
        len1   = WIDTH'(l1);
        exp_q.push_back(model_step(r, en, rq, l0, l1));
    endtask

    task automatic step(bit r, bit en, logic [1:0] rq, int l0, int l1);
        @(negedge clk);
        drive(r, en, rq, l0, l1);
    endtask

    task automatic check_int(string name, int act, int req_v);
        n_checks++;
        if (act == req_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
    endtask

    task automatic clear_counts();
        gnt_cycles  = 0;
        done_pulses = 0;
    endtask

    // Monitor: every clock the outputs are a fresh observation.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            a = '{gnt: gnt, done: done, busy: busy, cuenta: cuenta};
            if (gnt != 2'b00) gnt_cycles++;
            if (done != 2'b00) done_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow: output at %0t with no expectation", $time);
            end else begin
                e = exp_q.pop_front();
                if (a == e) n_pass++;
                else $display("FAIL cycle@%0t: got gnt=%b done=%b busy=%b cuenta=%0d, expected gnt=%b done=%b busy=%b cuenta=%0d",
                              $time, a.gnt, a.done, a.busy, a.cuenta,
                              e.gnt, e.done, e.busy, e.cuenta);
            end
        end
    end

    initial begin
        drive(1, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);

        // Single requester, len0=3.
        clear_counts();
        repeat (5) step(0, 1, 2'b01, 3, 9);
        repeat (3) step(0, 1, 2'b00, 3, 9);
        check_int("len3_gnt_cycles", gnt_cycles, 4);
        check_int("len3_done_pulses", done_pulses, 1);

        // Both held: alternation 0,1,0.
        step(1, 0, 2'b00, 0, 0);
        repeat (14) step(0, 1, 2'b11, 2, 1);
        step(1, 0, 2'b00, 0, 0);

        // Enable stall of two cycles at cuenta=2.
        clear_counts();
        repeat (3) step(0, 1, 2'b01, 4, 0);
        repeat (2) step(0, 0, 2'b01, 4, 0);
        repeat (3) step(0, 1, 2'b01, 4, 0);
        repeat (3) step(0, 1, 2'b00, 4, 0);
        check_int("stall_gnt_cycles", gnt_cycles, 7);

        // Zero target.
        clear_counts();
        repeat (2) step(0, 1, 2'b01, 0, 0);
        repeat (3) step(0, 1, 2'b00, 0, 0);
        check_int("len0_gnt_cycles", gnt_cycles, 1);
        check_int("len0_done_pulses", done_pulses, 1);

        // Abort at cuenta=1 with requester 1 pending.
        step(1, 0, 2'b00, 0, 0);
        clear_counts();
        repeat (2) step(0, 1, 2'b11, 5, 0);
        repeat (4) step(0, 1, 2'b10, 5, 0);
        step(0, 1, 2'b00, 5, 0);
        check_int("abort_done_pulses", done_pulses, 1);

        // Reset mid-run at cuenta=3, then contention grants requester 0.
        clear_counts();
        repeat (4) step(0, 1, 2'b01, 5, 5);
        step(1, 1, 2'b01, 5, 5);
        step(0, 1, 2'b11, 5, 5);
        step(0, 1, 2'b00, 5, 5);
        check_int("reset_no_done", done_pulses, 0);

        // Randomized traffic with sticky requests and occasional reset.
        begin
            logic [1:0] rq = 2'b00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) rq = 2'($urandom);
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rq,
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
        end

        step(0, 0, 2'b00, 0, 0);
        @(posedge clk);
        #2;
        check_int("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
